counter_seq_ctrl: RTL

Controller that sequences an external WIDTH-bit up/down counter datapath. It accepts START/STOP/STEP/LOAD commands over a valid/ready handshake and paces counting with a programmable prescaler. It drives one-cycle enable and load strobes and stops or wraps at terminal count. It sits between the top-level pin decoder and the counter instance.

---
 rtl/counter_seq_pkg.sv | 16 +
 rtl/counter_seq_ctrl_if.sv | 25 ++
 rtl/tick_prescaler.sv | 31 +++
 rtl/counter_seq_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and command encodings for the counter sequencing controller.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command handshake bundle between the pin decoder (master) and the controller (slave).
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running tick generator; period is max(div,1)+1 cycles, restarted by clr.
module tick_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] count;
  logic [PRESC_W-1:0] limit;

  // A divider of 0 is treated as 1 so the datapath always gets a settle cycle.
  always_comb begin
    limit = (div == '0) ? PRESC_W'(1) : div;
    tick  = !clr && (count == limit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count >= limit)) begin
      count <= '0;
    end else begin
      count <= count + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequences an external up/down counter: command FSM, prescaled ticks, terminal handling.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  counter_seq_ctrl_if.slave   cmd,
  input  logic                dir_up,
  input  logic                wrap_en,
  input  logic [PRESC_W-1:0]  presc_div,
  input  logic [WIDTH-1:0]    cnt_q,
  output logic                cnt_en,
  output logic                cnt_up,
  output logic                cnt_load,
  output logic [WIDTH-1:0]    load_val,
  output logic                tc_pulse,
  output logic                running
);

  state_t           state, state_n;
  logic             en_n, up_n, load_n, tc_n, running_n;
  logic [WIDTH-1:0] lv_n;
  logic             accept, clr, tick, do_tick, terminal;

  tick_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .div  (presc_div),
    .tick (tick)
  );

  always_comb begin
    cmd.cmd_ready = (state != STEP);
  end

  always_comb begin
    state_n  = state;
    en_n     = 1'b0;
    load_n   = 1'b0;
    tc_n     = 1'b0;
    up_n     = cnt_up;
    lv_n     = load_val;
    do_tick  = 1'b0;
    accept   = cmd.cmd_valid && cmd.cmd_ready;
    clr      = (state == IDLE) || (state == HALT);
    terminal = cnt_up ? (cnt_q == '1) : (cnt_q == '0);

    case (state)
      IDLE, HALT: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: begin state_n = RUN;  up_n = dir_up; end
            OP_STEP:  begin state_n = STEP; up_n = dir_up; end
            OP_LOAD:  begin state_n = IDLE; load_n = 1'b1; lv_n = cmd.cmd_data; end
            default:  state_n = IDLE;
          endcase
        end
      end
      RUN: begin
        // Any accepted command swallows a coincident tick.
        if (accept) begin
          case (cmd.cmd_op)
            OP_STOP:  state_n = IDLE;
            OP_START: begin clr = 1'b1; up_n = dir_up; end
            OP_LOAD:  begin load_n = 1'b1; lv_n = cmd.cmd_data; end
            default:  ;
          endcase
        end else begin
          do_tick = tick;
        end
      end
      STEP: begin
        if (tick) begin
          state_n = IDLE;
          do_tick = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_tick) begin
      en_n = !terminal || wrap_en;
      tc_n = terminal;
      if (terminal && !wrap_en) state_n = HALT;
    end

    running_n = (state_n == RUN) || (state_n == STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_en   <= 1'b0;
      cnt_up   <= 1'b0;
      cnt_load <= 1'b0;
      load_val <= '0;
      tc_pulse <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt_en   <= en_n;
      cnt_up   <= up_n;
      cnt_load <= load_n;
      load_val <= lv_n;
      tc_pulse <= tc_n;
      running  <= running_n;
    end
  end

endmodule
